// File: rtl/out_sig_compactor_if.sv
// Sample-in / record-out bundle for out_sig_compactor.
// Ports: in_valid/in_data/flush samples in; rec_* + overflow out (valid/ready).
interface out_sig_compactor_if #(
    parameter int DATA_W = 330
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              rec_valid;
    logic              rec_ready;
    logic [31:0]       rec_sig;
    logic [31:0]       rec_index;
    logic [15:0]       rec_samples;
    logic [15:0]       rec_toggles;
    logic              rec_partial;
    logic              overflow;

    modport slave (
        input  in_valid, in_data, flush, rec_ready,
        output rec_valid, rec_sig, rec_index,
        output rec_samples, rec_toggles, rec_partial,
        output overflow
    );

    modport master (
        output in_valid, in_data, flush, rec_ready,
        input  rec_valid, rec_sig, rec_index,
        input  rec_samples, rec_toggles, rec_partial,
        input  overflow
    );
endinterface

// File: rtl/out_sig_compactor.sv
// Compresses a wide output stream into per-window 32-bit MISR records.
// Ports: clk, rst (sync, active-high), bus (slave: samples in, records out).
module out_sig_compactor #(
    parameter int          DATA_W = 330,
    parameter int          WINDOW = 64,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
    input logic                clk,
    input logic                rst,
    out_sig_compactor_if.slave bus
);
    localparam int          LANES = (DATA_W + 31) / 32;
    localparam int          PAD_W = LANES * 32;
    localparam logic [15:0] WIN16 = 16'(WINDOW);

    logic [PAD_W-1:0]  padded;
    logic [31:0]       fold;
    logic [31:0]       sig;
    logic [15:0]       cnt;
    logic [15:0]       tog;
    logic [DATA_W-1:0] prev;
    logic [31:0]       idx;

    logic [31:0] sig_upd;
    logic [15:0] cnt_upd;
    logic [15:0] tog_upd;
    logic        close;
    logic        slot_free;

    assign padded = PAD_W'(bus.in_data);

    always_comb begin
        fold = '0;
        for (int k = 0; k < LANES; k++) begin
            fold ^= padded[32*k +: 32];
        end
    end

    // Post-update view of the window; the record is built from it.
    always_comb begin
        sig_upd = sig;
        cnt_upd = cnt;
        tog_upd = tog;
        if (bus.in_valid) begin
            sig_upd = {sig[30:0], 1'b0}
                    ^ (sig[31] ? POLY : 32'd0)
                    ^ fold;
            cnt_upd = cnt + 16'd1;
            tog_upd = tog + 16'(bus.in_data != prev);
        end
        close = (bus.in_valid && cnt_upd == WIN16)
             || (bus.flush && cnt_upd != 16'd0);
        slot_free = !bus.rec_valid || bus.rec_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig             <= SEED;
            cnt             <= '0;
            tog             <= '0;
            prev            <= '0;
            idx             <= '0;
            bus.rec_valid   <= 1'b0;
            bus.rec_sig     <= '0;
            bus.rec_index   <= '0;
            bus.rec_samples <= '0;
            bus.rec_toggles <= '0;
            bus.rec_partial <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                prev <= bus.in_data;
            end
            if (close) begin
                sig <= SEED;
                cnt <= '0;
                tog <= '0;
                // Index advances even when the record is dropped.
                idx <= idx + 32'd1;
                if (slot_free) begin
                    bus.rec_valid   <= 1'b1;
                    bus.rec_sig     <= sig_upd;
                    bus.rec_index   <= idx;
                    bus.rec_samples <= cnt_upd;
                    bus.rec_toggles <= tog_upd;
                    bus.rec_partial <= cnt_upd < WIN16;
                end else begin
                    bus.overflow <= 1'b1;
                end
            end else begin
                sig <= sig_upd;
                cnt <= cnt_upd;
                tog <= tog_upd;
                if (bus.rec_ready) begin
                    bus.rec_valid <= 1'b0;
                end
            end
        end
    end
endmodule
